// File: rtl/ram_prog_loader.sv
// Program loader and RAM access arbiter for the 16x8 SAP program/data RAM.
// The loader streams an image into sequential addresses, then reads the whole
// image back and checks it against a trailing 8-bit checksum. When the loader
// is idle, the CPU drives the RAM directly.
module ram_prog_loader #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_bus_in,
    input  logic          cpu_ram_out,
    input  logic          cpu_ram_in,
    output logic [DW-1:0] cpu_bus_out,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_bus_in,
    output logic          ram_out,
    output logic          ram_in,
    input  logic [DW-1:0] ram_bus_out,
    output logic          busy,
    output logic          pass,
    output logic          err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_RECV_CSUM,
        S_RD_ADDR,
        S_RD_SAMPLE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [DW-1:0] sum, sum_nxt;
    logic [DW-1:0] data_reg, data_nxt;
    logic [DW-1:0] csum_reg, csum_nxt;
    logic          pass_nxt, err_nxt;

    // State and datapath registers; reset aborts a load immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            addr     <= '0;
            sum      <= '0;
            data_reg <= '0;
            csum_reg <= '0;
            pass     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            sum      <= sum_nxt;
            data_reg <= data_nxt;
            csum_reg <= csum_nxt;
            pass     <= pass_nxt;
            err      <= err_nxt;
        end
    end

    // Next-state logic, RAM arbitration mux and stream handshake.
    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        sum_nxt     = sum;
        data_nxt    = data_reg;
        csum_nxt    = csum_reg;
        pass_nxt    = pass;
        err_nxt     = err;
        in_ready    = 1'b0;
        busy        = 1'b1;
        ram_addr    = addr;
        ram_bus_in  = data_reg;
        ram_out     = 1'b0;
        ram_in      = 1'b0;
        cpu_bus_out = '0;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                // CPU owns the RAM; the loader is transparent.
                busy        = 1'b0;
                ram_addr    = cpu_addr;
                ram_bus_in  = cpu_bus_in;
                ram_out     = cpu_ram_out;
                ram_in      = cpu_ram_in;
                cpu_bus_out = ram_bus_out;
                if (start) begin
                    state_nxt = S_RECV;
                    addr_nxt  = '0;
                    sum_nxt   = '0;
                    pass_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                end
            end
            S_RECV: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_nxt  = in_data;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                ram_in = 1'b1;
                if (addr == LAST_ADDR) begin
                    addr_nxt  = '0;
                    state_nxt = S_RECV_CSUM;
                end else begin
                    addr_nxt  = addr + 1'b1;
                    state_nxt = S_RECV;
                end
            end
            S_RECV_CSUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    csum_nxt  = in_data;
                    state_nxt = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                // Present the address; the RAM returns data next cycle.
                ram_out   = 1'b1;
                state_nxt = S_RD_SAMPLE;
            end
            S_RD_SAMPLE: begin
                ram_out = 1'b1;
                sum_nxt = sum + ram_bus_out;
                if (addr == LAST_ADDR) begin
                    state_nxt = S_CHECK;
                end else begin
                    addr_nxt  = addr + 1'b1;
                    state_nxt = S_RD_ADDR;
                end
            end
            S_CHECK: begin
                if (sum == csum_reg) begin
                    pass_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = S_ERR;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_prog_loader.sv
// Self-checking bench for ram_prog_loader: a behavioural RAM, an expected-write
// scoreboard and a per-cycle arbitration checker, driven by directed and
// randomized image loads.
module tb_ram_prog_loader;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_bus_in;
    logic          cpu_ram_out;
    logic          cpu_ram_in;
    logic [DW-1:0] cpu_bus_out;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_bus_in;
    logic          ram_out;
    logic          ram_in;
    logic [DW-1:0] ram_bus_out;
    logic          busy;
    logic          pass;
    logic          err;

    ram_prog_loader #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cpu_addr    (cpu_addr),
        .cpu_bus_in  (cpu_bus_in),
        .cpu_ram_out (cpu_ram_out),
        .cpu_ram_in  (cpu_ram_in),
        .cpu_bus_out (cpu_bus_out),
        .ram_addr    (ram_addr),
        .ram_bus_in  (ram_bus_in),
        .ram_out     (ram_out),
        .ram_in      (ram_in),
        .ram_bus_out (ram_bus_out),
        .busy        (busy),
        .pass        (pass),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Behavioural 16x8 RAM: synchronous write, registered read.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q = '0;
    assign ram_bus_out = rd_q;
    always @(posedge clk) begin
        if (ram_in)  mem[ram_addr] <= ram_bus_in;
        if (ram_out) rd_q <= mem[ram_addr];
    end

    typedef struct {
        int a;
        int d;
    } wr_t;

    wr_t           exp_wr[$];
    logic [DW-1:0] img [DEPTH];
    int            ntests = 0;
    int            nfail  = 0;
    int            busy_cnt = 0;
    bit            rand_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Per-cycle checker: arbitration, exclusivity and the write scoreboard.
    always @(negedge clk) begin
        wr_t w;
        if (!rst_n) begin
            chk("rst_busy", int'(busy), 0);
            chk("rst_in_ready", int'(in_ready), 0);
        end else if (!busy) begin
            chk("idle_in_ready", int'(in_ready), 0);
            chk("pt_addr", int'(ram_addr), int'(cpu_addr));
            chk("pt_bus_in", int'(ram_bus_in), int'(cpu_bus_in));
            chk("pt_ram_out", int'(ram_out), int'(cpu_ram_out));
            chk("pt_ram_in", int'(ram_in), int'(cpu_ram_in));
            chk("pt_rdata", int'(cpu_bus_out), int'(ram_bus_out));
        end else begin
            busy_cnt++;
            chk("ld_cpu_bus_out", int'(cpu_bus_out), 0);
            chk("ld_rw_excl", int'(ram_in & ram_out), 0);
            if (ram_in) begin
                chk("ld_wr_pending", int'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    chk("ld_wr_addr", int'(ram_addr), w.a);
                    chk("ld_wr_data", int'(ram_bus_in), w.d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_en) begin
            cpu_addr    = AW'($urandom);
            cpu_bus_in  = DW'($urandom);
            cpu_ram_out = 1'($urandom);
        end
    endtask

    task automatic send_byte(input logic [DW-1:0] b, input int gap);
        bit ok;
        int n;
        in_valid = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            step();
            n++;
        end
        chk("send_handshake", int'(ok), 1);
    endtask

    // One complete load of img[] plus checksum, then result checks.
    // gap_mode: 0 = full speed, 1 = valid 1-0-0-1 pattern, 2 = random gaps.
    task automatic run_load(input string tag, input logic [DW-1:0] csum, input int gap_mode,
                            input int mid_start, input bit cpu_attack, input bit full_speed);
        int sum;
        int gap;
        int to;
        int bad;
        bit exp_pass;
        sum = 0;
        for (int i = 0; i < DEPTH; i++) sum += int'(img[i]);
        exp_pass = ((sum % 256) == int'(csum));
        exp_wr.delete();
        for (int i = 0; i < DEPTH; i++) exp_wr.push_back('{i, int'(img[i])});
        in_valid = 1'b0;
        busy_cnt = 0;
        rand_en  = !cpu_attack;
        start = 1'b1;
        step();
        start = 1'b0;
        if (cpu_attack) begin
            cpu_ram_in = 1'b1;
            cpu_addr   = 4'd3;
            cpu_bus_in = 8'hAA;
        end
        for (int i = 0; i <= DEPTH; i++) begin
            if (gap_mode == 0)      gap = 0;
            else if (gap_mode == 1) gap = (i % 2 == 1) ? 2 : 0;
            else                    gap = int'($urandom_range(0, 3));
            if (i == mid_start) begin
                in_valid = 1'b0;
                start = 1'b1;
                step();
                start = 1'b0;
            end
            send_byte((i < DEPTH) ? img[i] : csum, gap);
        end
        in_valid = 1'b0;
        to = 0;
        @(negedge clk);
        while (busy && to < 300) begin
            step();
            @(negedge clk);
            to++;
        end
        // Release the CPU before the next edge so nothing leaks into idle.
        rand_en     = 1'b0;
        cpu_ram_in  = 1'b0;
        cpu_ram_out = 1'b0;
        chk({tag, "_done"}, int'(busy), 0);
        chk({tag, "_pass"}, int'(pass), int'(exp_pass));
        chk({tag, "_err"}, int'(err), int'(!exp_pass));
        chk({tag, "_writes_left"}, exp_wr.size(), 0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== img[i]) bad++;
        chk({tag, "_ram_image"}, bad, 0);
        if (full_speed) chk({tag, "_busy_cycles"}, busy_cnt, 66);
        step();
    endtask

    initial begin
        logic [DW-1:0] cs;
        int s;
        rst_n = 1'b0;
        start = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        cpu_addr = '0;
        cpu_bus_in = '0;
        cpu_ram_out = 1'b0;
        cpu_ram_in = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("reset_pass", int'(pass), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_busy", int'(busy), 0);
        #1;
        rst_n = 1'b1;
        step();

        // 1: ascending image, correct checksum 0x78, then CPU reads addr 9.
        for (int i = 0; i < DEPTH; i++) img[i] = DW'(i);
        run_load("t1", 8'h78, 0, -1, 1'b0, 1'b1);
        chk("t1_pass_lit", int'(pass), 1);
        cpu_addr = 4'd9;
        cpu_ram_out = 1'b1;
        step();
        @(negedge clk);
        chk("t1_cpu_read9", int'(cpu_bus_out), 9);
        #1;
        cpu_ram_out = 1'b0;
        step();

        // 2: same image, wrong checksum.
        run_load("t2", 8'h77, 0, -1, 1'b0, 1'b1);
        chk("t2_err_lit", int'(err), 1);
        chk("t2_pass_lit", int'(pass), 0);

        // 3: all 0xFF, checksum wraps to 0xF0.
        for (int i = 0; i < DEPTH; i++) img[i] = 8'hFF;
        run_load("t3", 8'hF0, 0, -1, 1'b0, 1'b1);
        chk("t3_pass_lit", int'(pass), 1);

        // 4: random image with valid toggling 1-0-0-1.
        s = 0;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = DW'($urandom);
            s += int'(img[i]);
        end
        run_load("t4", DW'(s), 1, -1, 1'b0, 1'b0);

        // 5: CPU write to addr 3 during a load is blocked; while idle it lands.
        for (int i = 0; i < DEPTH; i++) img[i] = DW'(i);
        run_load("t5", 8'h78, 0, -1, 1'b1, 1'b1);
        cpu_addr = 4'd3;
        cpu_bus_in = 8'hAA;
        cpu_ram_in = 1'b1;
        step();
        cpu_ram_in = 1'b0;
        @(negedge clk);
        chk("t5_idle_write", int'(mem[3]), 'hAA);
        step();

        // 6: reset after the 5th byte, then a full reload with a stray start.
        for (int i = 0; i < DEPTH; i++) img[i] = DW'(8'h30 + i);
        exp_wr.delete();
        for (int i = 0; i < 4; i++) exp_wr.push_back('{i, int'(img[i])});
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(img[i], 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_in_ready", int'(in_ready), 0);
        chk("t6_rst_pass", int'(pass), 0);
        chk("t6_rst_err", int'(err), 0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        exp_wr.delete();
        step();
        s = 0;
        for (int i = 0; i < DEPTH; i++) s += int'(img[i]);
        run_load("t6", DW'(s), 0, 8, 1'b0, 1'b0);
        chk("t6_pass_lit", int'(pass), 1);

        // Randomized loads: random images, random stalls, good or bad checksum.
        for (int k = 0; k < 6; k++) begin
            s = 0;
            for (int i = 0; i < DEPTH; i++) begin
                img[i] = DW'($urandom);
                s += int'(img[i]);
            end
            cs = DW'(s);
            if ($urandom_range(0, 1) == 1) cs = cs ^ DW'($urandom_range(1, 255));
            run_load("rnd", cs, 2, -1, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
